// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, frame FSM states and the parity helper,
// used by both the transmitter and receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    PARITY_NONE,
    PARITY_EVEN,
    PARITY_ODD
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  // Even parity is the XOR of the data bits; odd parity is its inverse.
  function automatic logic parity_bit(input logic [7:0] data, input parity_e mode);
    return (^data) ^ (mode == PARITY_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO for the UART transmitter: power-of-two depth, combinational head read,
// pointers wrap naturally modulo depth.
module uart_tx_fifo #(
  parameter int depth = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] pop_data,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;

  if (depth < 2 || (depth & (depth - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: depth must be a power of 2 and at least 2");
  end

  logic [7:0]    mem_q [depth];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push;
  logic          do_pop;

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign full     = (count_q == CW'(depth));
  assign empty    = (count_q == '0);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: AXI-stream byte input through a small FIFO, 8 data bits LSB first,
// optional parity, one or two stop bits, registered tx line.
module uart_tx
  import uart_pkg::*;
#(
  parameter int      cycles_per_bit = 434,
  parameter int      fifo_depth     = 4,
  parameter parity_e parity         = PARITY_NONE,
  parameter int      stop_bits      = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tvalid,
  output logic       tready,
  input  logic [7:0] tdata,
  output logic       tx,
  output logic       busy
);

  localparam int          CW        = $clog2(cycles_per_bit);
  localparam logic [CW-1:0] CPB_M1  = CW'(cycles_per_bit - 1);
  localparam logic        LAST_STOP = (stop_bits == 2);

  if (cycles_per_bit < 2) begin : g_bad_cpb
    $error("uart_tx: cycles_per_bit must be at least 2");
  end
  if (stop_bits != 1 && stop_bits != 2) begin : g_bad_stop
    $error("uart_tx: stop_bits must be 1 or 2");
  end

  uart_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic          stop_q, stop_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          ready_q, ready_d;

  logic          tick;
  logic          start_frame;
  logic          pop;
  logic          full;
  logic          empty;
  logic [7:0]    fifo_data;

  uart_tx_fifo #(
    .depth(fifo_depth)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (tvalid && tready),
    .push_data(tdata),
    .pop      (pop),
    .pop_data (fifo_data),
    .full     (full),
    .empty    (empty)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    stop_d      = stop_q;
    shift_d     = shift_q;
    par_d       = par_q;
    busy_d      = busy_q;
    ready_d     = 1'b1;
    pop         = 1'b0;
    start_frame = 1'b0;
    tick        = (cnt_q == '0);

    if (state_q != IDLE) begin
      cnt_d = tick ? CPB_M1 : cnt_q - CW'(1);
    end

    case (state_q)
      IDLE: begin
        busy_d      = 1'b0;
        start_frame = !empty;
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_q == 3'd7) begin
            state_d = (parity != PARITY_NONE) ? PARITY : STOP;
            stop_d  = 1'b0;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_d = STOP;
          stop_d  = 1'b0;
        end
      end
      STOP: begin
        if (tick) begin
          if (stop_q == LAST_STOP) begin
            // Chain straight into the next start bit when a byte is waiting.
            if (!empty) begin
              start_frame = 1'b1;
            end else begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (start_frame) begin
      pop     = 1'b1;
      state_d = START;
      cnt_d   = CPB_M1;
      shift_d = fifo_data;
      par_d   = parity_bit(fifo_data, parity);
      busy_d  = 1'b1;
    end

    // tx is registered from the next state so it changes on the transition edge.
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  assign tready = ready_q && !full;
  assign tx     = tx_q;
  assign busy   = busy_q;

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter: cycles_per_bit, default 434, clk cycles per serial bit; values below 2 SHALL fail elaboration.
REQ-002 SHALL have parameter: fifo_depth, default 4, byte FIFO entries; must be a power of 2 and at least 2, else elaboration SHALL fail.
REQ-003 SHALL have parameter: parity, default PARITY_NONE, one of PARITY_NONE / PARITY_EVEN / PARITY_ODD.
REQ-004 SHALL have parameter: stop_bits, default 1, legal values 1 or 2.
REQ-005 SHALL have port: clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port: tvalid  input  1  AXI-stream byte valid.
REQ-008 SHALL have port: tready  output  1  AXI-stream ready.
REQ-009 SHALL have port: tdata  input  8  AXI-stream byte.
REQ-010 SHALL have port: tx  output  1  serial line, idle high.
REQ-011 SHALL have port: busy  output  1  frame in progress on tx.

Function
REQ-012 SHALL accept a byte on any rising edge where tvalid=1 and tready=1, storing tdata as it is at that edge.
REQ-013 SHALL drive tready = not FIFO-full; tvalid SHALL never gate tready.
REQ-014 SHALL use FSM states IDLE, START, DATA, PARITY, STOP: IDLE->START on FIFO non-empty (pop); START->DATA; DATA->PARITY after bit 7 if parity enabled, else ->STOP; PARITY->STOP; STOP->START if FIFO non-empty at last stop cycle, else ->IDLE.
REQ-015 SHALL hold every bit exactly cycles_per_bit cycles using a down-counter reloaded to cycles_per_bit-1.
REQ-016 SHALL send start bit 0, 8 data bits LSB first, optional parity bit, then stop_bits high bits.
REQ-017 SHALL make the parity bit the XOR of the data bits for PARITY_EVEN and its inverse for PARITY_ODD.
REQ-018 SHALL drive tx low from the first rising edge after the acceptance edge when FSM is IDLE and FIFO is empty (1-cycle latency).
REQ-019 SHALL start back-to-back frames with no idle cycle between the last stop-bit cycle and the next start bit.
REQ-020 SHALL register tx; tx SHALL be 1 in IDLE and STOP.
REQ-021 SHALL assert busy from the pop edge through the final stop-bit cycle, deasserting on return to IDLE.
REQ-022 SHALL leave the FIFO count unchanged on simultaneous push and pop; a pop on a full FIFO raises tready on the next cycle only.
REQ-023 SHALL transmit bytes in acceptance order; the FIFO pointers SHALL wrap modulo fifo_depth.

Reset
REQ-024 SHALL, while rst_n=0, force tx=1, tready=0, busy=0, FSM=IDLE and FIFO empty, asynchronously.
REQ-025 SHALL abandon any frame in progress when reset is asserted mid-frame, with no partial frame resumed after release.
REQ-026 SHALL assert tready=1 on the first rising edge after rst_n deasserts.

Structure
REQ-027 SHALL place the parity enum (PARITY_NONE/EVEN/ODD) and the FSM state enum in shared package uart_pkg, for reuse by uart_rx.
REQ-028 SHALL implement the byte FIFO as sub-module uart_tx_fifo (parameterised depth, push/pop/full/empty).

Verification
REQ-029 SHALL cover: reset then 100 idle cycles -> tx=1, tready=1, busy=0 throughout.
REQ-030 SHALL cover: send 0x4D (parity none, 1 stop) -> tx = 0,1,0,1,1,0,0,1,0,1, each bit 434 cycles; looped into uart_rx, tdata=77 and num_overflows=0.
REQ-031 SHALL cover: fifo_depth=4 with 6 bytes presented back-to-back -> tready low after the 5th acceptance; all 6 frames sent in order with zero-gap frame boundaries.
REQ-032 SHALL cover: 0x4D with PARITY_EVEN -> parity bit 0; with PARITY_ODD -> 1; with stop_bits=2 -> stop high 868 cycles before the next start bit.
REQ-033 SHALL cover: rst_n pulsed low during data bit 3 -> tx=1 immediately, busy=0, tready=1 one edge after release, no further line activity.
REQ-034 SHALL cover: tdata changed from 0x4D to 0xFF while tready=0 and accepted as 0xFF -> frame carries 0xFF only.
